// File: rtl/proc_pkg.sv
// Shared types and default widths for the instruction prefetch slice.
package proc_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_INSTR_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        DISCARD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch queue: DEPTH entries of {instruction, pc}, flushable, head read is zero when empty.
module prefetch_fifo
    import proc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DEF_INSTR_W + DEF_ADDR_W
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; the head is masked whenever the queue is empty.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i && !rst_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign rd_data_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o   = count_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: one-outstanding fetch FSM feeding a small queue.
// Optional macro PREFETCH_STATS_EN adds a saturating 16-bit accepted-ack counter.
//
//   state    | meaning
//   IDLE     | no request; waits for queue space
//   WAIT_ACK | request at mem_addr outstanding; ack pushes into queue
//   DISCARD  | redirected while waiting; ack is dropped, then fetch new target
module instr_prefetch
    import proc_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               CLB,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] Instruction,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_take,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
`ifdef PREFETCH_STATS_EN
    ,
    output logic [15:0]        fetch_count
`endif
);

    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_state_e        state_q;
    logic [ADDR_W-1:0]   fetch_pc_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_req_q;
    logic [CNT_W-1:0]    count;
    logic [CNT_W:0]      occ_d;
    logic                ack_acc;
    logic                push;
    logic                pop;
    logic                has_space_d;

    // Redirect wins over both push and pop in the same cycle.
    assign ack_acc     = mem_req_q & mem_ack;
    assign push        = ack_acc & (state_q == WAIT_ACK) & ~redirect;
    assign pop         = instr_take & instr_valid & ~redirect;
    assign occ_d       = {1'b0, count} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
    assign has_space_d = occ_d < (CNT_W+1)'(DEPTH);

    always_ff @(posedge clk) begin
        if (CLB) begin
            state_q    <= IDLE;
            fetch_pc_q <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc_q <= redirect_pc;
                    end else if (count < CNT_W'(DEPTH)) begin
                        state_q    <= WAIT_ACK;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= fetch_pc_q;
                    end
                end
                WAIT_ACK: begin
                    if (redirect) begin
                        fetch_pc_q <= redirect_pc;
                        if (ack_acc) mem_addr_q <= redirect_pc;
                        else         state_q    <= DISCARD;
                    end else if (ack_acc) begin
                        fetch_pc_q <= fetch_pc_q + 1'b1;
                        if (has_space_d) begin
                            mem_addr_q <= fetch_pc_q + 1'b1;
                        end else begin
                            state_q   <= IDLE;
                            mem_req_q <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    // Queue was flushed on entry, so there is always room to refetch.
                    if (redirect) fetch_pc_q <= redirect_pc;
                    if (ack_acc) begin
                        state_q    <= WAIT_ACK;
                        mem_addr_q <= redirect ? redirect_pc : fetch_pc_q;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W + ADDR_W)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (CLB),
        .flush_i   (redirect),
        .push_i    (push),
        .wr_data_i ({mem_data, fetch_pc_q}),
        .pop_i     (pop),
        .rd_data_o ({Instruction, instr_pc}),
        .count_o   (count)
    );

    assign instr_valid = (count != '0);
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

`ifdef PREFETCH_STATS_EN
    logic [15:0] fetch_count_q;

    always_ff @(posedge clk) begin
        if (CLB)                                   fetch_count_q <= '0;
        else if (ack_acc && fetch_count_q != 16'hFFFF) fetch_count_q <= fetch_count_q + 1'b1;
    end

    assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed scoreboard bench for instr_prefetch; stats checks active under PREFETCH_STATS_EN.
module tb_instr_prefetch;

    logic       clk = 1'b0;
    logic       CLB = 1'b1;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_data = 8'h00;
    logic [7:0] Instruction;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_take = 1'b0;
    logic       redirect = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
`ifdef PREFETCH_STATS_EN
    logic [15:0] fetch_count;
`endif

    instr_prefetch #(.DEPTH(4), .ADDR_W(8), .INSTR_W(8)) dut (
        .clk         (clk),
        .CLB         (CLB),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .Instruction (Instruction),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_take  (instr_take),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef PREFETCH_STATS_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int pops    = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  ack_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory model: data = addr + 0x10; ack after lat cycles (0 = first request cycle).
    int         base_lat  = 0;
    int         slow_lat  = 0;
    logic [7:0] slow_addr = 8'hAA;
    int         wcnt      = 0;
    bit         prev_req  = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (mem_req === 1'b1) begin
            if (!prev_req || mem_ack) wcnt = 0;
            else                      wcnt++;
            mem_ack  = (wcnt >= ((mem_addr == slow_addr) ? slow_lat : base_lat));
            mem_data = mem_addr + 8'h10;
        end else begin
            wcnt     = 0;
            mem_ack  = 1'b0;
            mem_data = 8'h00;
        end
        prev_req = (mem_req === 1'b1);
    end

    logic [15:0] sb_e;
    always @(negedge clk) begin
        if (instr_valid && instr_take && !redirect && !CLB) begin
            pops++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got pc 0x%0h instr 0x%0h, expected no pop", instr_pc, Instruction);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_head", {Instruction, instr_pc}, sb_e);
            end
        end
    end

    logic       hold_prev = 1'b0;
    logic [7:0] addr_prev = 8'h00;
    always @(negedge clk) begin
        if (mem_req && mem_ack && !CLB) ack_log.push_back(mem_addr);
        if (hold_prev && mem_req) check("addr_hold", mem_addr, addr_prev);
        hold_prev = mem_req && !mem_ack && !CLB;
        addr_prev = mem_addr;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        CLB = 1'b1;
        tick(2);
        ack_log.delete();
        CLB = 1'b0;
    endtask

    task automatic wait_req_addr(input string name, input logic [7:0] a);
        int i;
        for (i = 0; i < 50; i++) begin
            if (mem_req && mem_addr == a) break;
            tick();
        end
        n_tests++;
        if (i >= 50) begin
            n_fail++;
            $display("FAIL %s: timeout, mem_addr 0x%0h, expected request at 0x%0h", name, mem_addr, a);
        end
    endtask

    task automatic take_n(input int n);
        for (int k = 0; k < n; k++) begin
            int i;
            for (i = 0; i < 50; i++) begin
                if (instr_valid) break;
                tick();
            end
            if (i >= 50) begin
                n_tests++;
                n_fail++;
                $display("FAIL take_wait: timeout, instr_valid 0, expected 1");
            end
            instr_take = 1'b1;
            tick();
            instr_take = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, then ack-same-cycle fill with no take.
        CLB = 1'b1;
        tick(2);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", Instruction, 0);
        check("rst_pc", instr_pc, 0);
        ack_log.delete();
        CLB = 1'b0;
        tick(1);
        check("first_req", mem_req, 1);
        check("first_addr", mem_addr, 0);
        check("valid_before_ack", instr_valid, 0);
        tick(1);
        check("valid_latency1", instr_valid, 1);
        tick(8);
        check("fill_acks", ack_log.size(), 4);
        for (int k = 0; k < 4 && k < ack_log.size(); k++) check("fill_addr", ack_log[k], k);
        check("full_req_low", mem_req, 0);
        check("full_valid", instr_valid, 1);
        check("full_instr", Instruction, 8'h10);
        check("full_pc", instr_pc, 8'h00);

        // Continuous take: no gaps, sequential pcs.
        for (int k = 0; k < 16; k++) exp_q.push_back({8'(8'h10 + k), 8'(k)});
        pops = 0;
        instr_take = 1'b1;
        tick(16);
        instr_take = 1'b0;
        check("stream_pops", pops, 16);

        // Reset while a request is outstanding.
        base_lat = 1000;
        do_reset();
        tick(3);
        check("pend_req", mem_req, 1);
        CLB = 1'b1;
        tick(1);
        check("midrst_req", mem_req, 0);
        check("midrst_valid", instr_valid, 0);
        base_lat = 0;
        CLB = 1'b0;
        tick(1);
        check("rst_reissue_req", mem_req, 1);
        check("rst_reissue_addr", mem_addr, 0);
        check("rst_no_stale_ack", ack_log.size(), 0);
        tick(6);

        // Redirect to 0x40 while waiting on a 3-cycle ack for 0x02.
        slow_addr = 8'h02;
        slow_lat  = 2;
        do_reset();
        wait_req_addr("wait_0x02", 8'h02);
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        tick(1);
        redirect = 1'b0;
        check("disc_req", mem_req, 1);
        check("disc_addr", mem_addr, 8'h02);
        check("disc_flush", instr_valid, 0);
        tick(1);
        check("disc_addr2", mem_addr, 8'h02);
        tick(1);
        check("disc_next_addr", mem_addr, 8'h40);
        check("disc_drop", instr_valid, 0);
        slow_lat = 0;
        exp_q.push_back({8'h50, 8'h40});
        exp_q.push_back({8'h51, 8'h41});
        take_n(2);
        check("disc_log_0x40", (ack_log.size() > 3) ? ack_log[3] : 8'hXX, 8'h40);

        // fetch_pc wraps 0xFF -> 0x00.
        do_reset();
        tick(8);
        ack_log.delete();
        redirect    = 1'b1;
        redirect_pc = 8'hFE;
        tick(1);
        redirect = 1'b0;
        check("idle_redir_flush", instr_valid, 0);
        tick(8);
        check("wrap_acks", ack_log.size(), 4);
        for (int k = 0; k < 4 && k < ack_log.size(); k++) check("wrap_addr", ack_log[k], 8'(8'hFE + k));
        check("wrap_head_pc", instr_pc, 8'hFE);
        check("wrap_head_instr", Instruction, 8'h0E);

        // Full queue: take and redirect together.
        instr_take  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 8'h80;
        tick(1);
        instr_take = 1'b0;
        redirect   = 1'b0;
        check("fullredir_valid", instr_valid, 0);
        check("fullredir_instr", Instruction, 0);
        check("fullredir_pc", instr_pc, 0);
        wait_req_addr("fullredir_0x80", 8'h80);
        exp_q.push_back({8'h90, 8'h80});
        take_n(1);

        // Redirect coinciding with ack, plus accepted-ack statistics.
        do_reset();
`ifdef PREFETCH_STATS_EN
        check("stats_rst", fetch_count, 0);
`endif
        tick(1);
        check("coinc_ack", mem_ack, 1);
        redirect    = 1'b1;
        redirect_pc = 8'h20;
        tick(1);
        redirect = 1'b0;
        check("coinc_addr", mem_addr, 8'h20);
        check("coinc_req", mem_req, 1);
        check("coinc_drop", instr_valid, 0);
        tick(1);
        check("coinc_valid", instr_valid, 1);
        check("coinc_pc", instr_pc, 8'h20);
        check("coinc_instr", Instruction, 8'h30);
        tick(6);
        exp_q.push_back({8'h30, 8'h20});
        take_n(1);
        tick(4);
`ifdef PREFETCH_STATS_EN
        check("stats_six", fetch_count, 6);
        CLB = 1'b1;
        tick(1);
        check("stats_clear", fetch_count, 0);
        CLB = 1'b0;
        tick(1);
`endif
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
